if_prefetch_stage: RTL and testbench

Parametrised successor of the instruction fetch stage. It decouples PC generation from ID with an N-entry fetch queue of {pc, inst} pairs and a valid/ready handshake to ID, replacing the roll and collision registers. It prioritises redirects: pc_start, then trap, then xRET, then jump. It shares the synchronous instruction RAM read port with the monitor. It sits between the instruction RAM and the ID stage.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fetch_fifo.sv | 42 ++++
 rtl/inst_1r1w.sv | 20 ++
 rtl/if_prefetch_stage.sv | 130 +++++++++++++
 tb/tb_if_prefetch_stage.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the prefetching instruction fetch stage.
package if_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        NONE,
        START,
        TRAP,
        XRET,
        JMP
    } redir_e;

    typedef struct packed {
        logic [31:2] pc;
        logic [31:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch queue of {pc, inst} entries with flush, concurrent push/pop and occupancy output.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push,
    input  fq_entry_t push_data,
    input  logic      pop,
    output fq_entry_t head,
    output logic [AW:0] level
);

    fq_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/inst_1r1w.sv
// Instruction RAM: one synchronous read port, one write port, old data on read/write collision.
module inst_1r1w #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] ram_radr,
    output logic [31:0]   ram_rdata,
    input  logic [AW-1:0] ram_wadr,
    input  logic [31:0]   ram_wdata,
    input  logic          ram_wen
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (ram_wen) mem[ram_wadr] <= ram_wdata;
        ram_rdata <= mem[ram_radr];
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with an FQ_DEPTH-entry prefetch queue and valid/ready hand-off to ID.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int          IRAM_AW  = 12,
    parameter int          FQ_DEPTH = 4,
    parameter logic [29:0] RESET_PC = 30'h0,
    parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pc_start,
    input  logic [29:0]               start_adr,
    input  logic                      trap_ex,
    input  logic [29:0]               trap_vec_ex,
    input  logic                      xret_ex,
    input  logic [29:0]               xret_adr_ex,
    input  logic                      jmp_condition_ex,
    input  logic [29:0]               jmp_adr_ex,
    output logic [31:0]               inst_id,
    output logic [29:0]               pc_id,
    output logic                      inst_valid_id,
    input  logic                      id_ready,
    output logic                      post_jump_cmd_cond,
    input  logic [IRAM_AW-1:0]        i_ram_radr,
    output logic [31:0]               i_ram_rdata,
    input  logic [IRAM_AW-1:0]        i_ram_wadr,
    input  logic [31:0]               i_ram_wdata,
    input  logic                      i_ram_wen,
    input  logic                      i_read_sel,
    output logic [31:0]               pc_data,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]               perf_redirect_cnt,
    output logic [31:0]               perf_bubble_cnt,
`endif
    output logic [$clog2(FQ_DEPTH):0] fq_level
);

    logic [29:0] fetch_pc, inflight_pc, redir_tgt, last_pc;
    logic        inflight, trap_sup;
    logic        redirect, issue, push, pop;
    logic [31:0] ram_rdata;
    redir_e      cause;
    fq_entry_t   head;

    // xRET and jump are masked for one cycle after a trap so a stale EX op cannot override mtvec.
    always_comb begin
        cause     = NONE;
        redir_tgt = fetch_pc;
        if (pc_start) begin
            cause     = START;
            redir_tgt = start_adr;
        end else if (trap_ex) begin
            cause     = TRAP;
            redir_tgt = trap_vec_ex;
        end else if (xret_ex && !trap_sup) begin
            cause     = XRET;
            redir_tgt = xret_adr_ex;
        end else if (jmp_condition_ex && !trap_sup) begin
            cause     = JMP;
            redir_tgt = jmp_adr_ex;
        end
    end

    // Counting the in-flight read as occupied guarantees its return always fits.
    assign redirect = (cause != NONE);
    assign issue    = !i_read_sel && !redirect &&
                      ((32'(fq_level) + 32'(inflight)) < 32'(FQ_DEPTH));
    assign push     = inflight && !redirect;
    assign pop      = inst_valid_id && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc           <= RESET_PC;
            inflight           <= 1'b0;
            inflight_pc        <= '0;
            trap_sup           <= 1'b0;
            post_jump_cmd_cond <= 1'b0;
            last_pc            <= '0;
        end else begin
            if (redirect)   fetch_pc <= redir_tgt;
            else if (issue) fetch_pc <= fetch_pc + 30'd1;
            inflight <= issue;
            if (issue) inflight_pc <= fetch_pc;
            trap_sup           <= (cause == TRAP);
            post_jump_cmd_cond <= xret_ex | jmp_condition_ex;
            if (inst_valid_id) last_pc <= head.pc;
        end
    end

    inst_1r1w #(.AW(IRAM_AW)) u_iram (
        .clk       (clk),
        .ram_radr  (i_read_sel ? i_ram_radr : fetch_pc[IRAM_AW-1:0]),
        .ram_rdata (ram_rdata),
        .ram_wadr  (i_ram_wadr),
        .ram_wdata (i_ram_wdata),
        .ram_wen   (i_ram_wen)
    );

    if_fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data ('{pc: inflight_pc, inst: ram_rdata}),
        .pop       (pop),
        .head      (head),
        .level     (fq_level)
    );

    assign inst_valid_id = (fq_level != '0);
    assign inst_id       = inst_valid_id ? head.inst : NOP_INST;
    assign pc_id         = inst_valid_id ? head.pc : last_pc;
    assign i_ram_rdata   = ram_rdata;
    assign pc_data       = {fetch_pc, 2'b00};

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirect_cnt <= '0;
            perf_bubble_cnt   <= '0;
        end else begin
            perf_redirect_cnt <= perf_redirect_cnt + 32'(redirect);
            perf_bubble_cnt   <= perf_bubble_cnt + 32'(id_ready && !inst_valid_id);
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: vector table, directed corner cases, random run vs queue model.
module tb_if_prefetch_stage;
    import if_pkg::*;

    localparam int          AW  = 12;
    localparam int          D   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pc_start = 0, trap_ex = 0, xret_ex = 0, jmp_condition_ex = 0;
    logic [29:0] start_adr = '0, trap_vec_ex = '0, xret_adr_ex = '0, jmp_adr_ex = '0;
    logic        id_ready = 0, i_read_sel = 0, i_ram_wen = 0;
    logic [AW-1:0] i_ram_radr = '0, i_ram_wadr = '0;
    logic [31:0] i_ram_wdata = '0;
    logic [31:0] inst_id, i_ram_rdata, pc_data;
    logic [29:0] pc_id;
    logic        inst_valid_id, post_jump_cmd_cond;
    logic [$clog2(D):0] fq_level;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_redirect_cnt, perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    if_prefetch_stage #(.IRAM_AW(AW), .FQ_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_start(pc_start), .start_adr(start_adr),
        .trap_ex(trap_ex), .trap_vec_ex(trap_vec_ex),
        .xret_ex(xret_ex), .xret_adr_ex(xret_adr_ex),
        .jmp_condition_ex(jmp_condition_ex), .jmp_adr_ex(jmp_adr_ex),
        .inst_id(inst_id), .pc_id(pc_id), .inst_valid_id(inst_valid_id),
        .id_ready(id_ready), .post_jump_cmd_cond(post_jump_cmd_cond),
        .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata),
        .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
        .i_read_sel(i_read_sel), .pc_data(pc_data),
`ifdef IF_PERF_CNT_EN
        .perf_redirect_cnt(perf_redirect_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .fq_level(fq_level)
    );

    int errs = 0, checks = 0;

    // Reference model: instruction stream as a queue plus the fetch pointer and one pending read.
    typedef struct { logic [29:0] pc; logic [31:0] inst; } ent_t;
    logic [31:0] ram_m [4096];
    ent_t        q[$];
    logic [29:0] m_fpc, m_ipc, m_last_pc;
    logic [31:0] m_iinst, m_mon, m_rcnt, m_bcnt;
    bit          m_infl, m_sup, m_pj, m_mon_v;

    task automatic m_reset();
        q.delete();
        m_fpc = '0; m_ipc = '0; m_last_pc = '0; m_iinst = '0; m_mon = '0;
        m_infl = 0; m_sup = 0; m_pj = 0; m_mon_v = 0; m_rcnt = '0; m_bcnt = '0;
    endtask

    task automatic model_edge();
        bit          valid, redir, can_issue;
        logic [29:0] tgt;
        valid = (q.size() != 0);
        redir = 1;
        tgt   = m_fpc;
        if (pc_start)                     tgt = start_adr;
        else if (trap_ex)                 tgt = trap_vec_ex;
        else if (xret_ex && !m_sup)       tgt = xret_adr_ex;
        else if (jmp_condition_ex && !m_sup) tgt = jmp_adr_ex;
        else                              redir = 0;
        can_issue = !i_read_sel && !redir && ((q.size() + int'(m_infl)) < D);
        if (valid) m_last_pc = q[0].pc;
        if (redir) m_rcnt = m_rcnt + 1;
        if (id_ready && !valid) m_bcnt = m_bcnt + 1;
        m_mon_v = i_read_sel;
        if (i_read_sel) m_mon = ram_m[i_ram_radr];
        if (redir) begin
            q.delete();
            m_infl = 0;
            m_fpc  = tgt;
        end else begin
            if (valid && id_ready) void'(q.pop_front());
            if (m_infl) q.push_back('{m_ipc, m_iinst});
            m_infl = can_issue;
            if (can_issue) begin
                m_ipc   = m_fpc;
                m_iinst = ram_m[m_fpc[AW-1:0]];
                m_fpc   = m_fpc + 30'd1;
            end
        end
        m_sup = redir && !pc_start && trap_ex;
        m_pj  = xret_ex | jmp_condition_ex;
        if (i_ram_wen) ram_m[i_ram_wadr] = i_ram_wdata;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        bit v;
        v = (q.size() != 0);
        chk("valid", 32'(inst_valid_id), 32'(v));
        chk("inst_id", inst_id, v ? q[0].inst : NOP);
        chk("pc_id", 32'(pc_id), 32'(v ? q[0].pc : m_last_pc));
        chk("fq_level", 32'(fq_level), 32'(q.size()));
        chk("pc_data", pc_data, {m_fpc, 2'b00});
        chk("post_jump", 32'(post_jump_cmd_cond), 32'(m_pj));
        if (m_mon_v) chk("mon_rdata", i_ram_rdata, m_mon);
`ifdef IF_PERF_CNT_EN
        chk("perf_redirect", perf_redirect_cnt, m_rcnt);
        chk("perf_bubble", perf_bubble_cnt, m_bcnt);
`endif
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_in();
        pc_start = 0; trap_ex = 0; xret_ex = 0; jmp_condition_ex = 0;
        i_read_sel = 0; i_ram_wen = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(inst_valid_id), 32'd0);
        chk({tag, "_inst"}, inst_id, NOP);
        chk({tag, "_pc_id"}, 32'(pc_id), 32'd0);
        chk({tag, "_level"}, 32'(fq_level), 32'd0);
        chk({tag, "_pc_data"}, pc_data, 32'd0);
        chk({tag, "_post_jump"}, 32'(post_jump_cmd_cond), 32'd0);
    endtask

    typedef struct {
        logic        start;
        logic [29:0] adr;
        logic        rdy;
        logic        exp_v;
        logic [29:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_pcdata;
    } vec_t;
    vec_t tbl[6];

    initial begin
        logic [31:0] d;
        logic [29:0] saved_pc;

        tbl[0] = '{1'b1, 30'h10, 1'b1, 1'b0, 30'h00, NOP,           32'h40};
        tbl[1] = '{1'b0, 30'h00, 1'b1, 1'b0, 30'h00, NOP,           32'h44};
        tbl[2] = '{1'b0, 30'h00, 1'b1, 1'b1, 30'h10, 32'hA000_0010, 32'h48};
        tbl[3] = '{1'b0, 30'h00, 1'b1, 1'b1, 30'h11, 32'hA000_0011, 32'h4C};
        tbl[4] = '{1'b0, 30'h00, 1'b1, 1'b1, 30'h12, 32'hA000_0012, 32'h50};
        tbl[5] = '{1'b0, 30'h00, 1'b1, 1'b1, 30'h13, 32'hA000_0013, 32'h54};

        m_reset();
        // RAM preload through the monitor write port while the stage is held in reset.
        @(negedge clk);
        for (int i = 0; i < 4096; i++) begin
            d = (i >= 16 && i < 20) ? (32'hA000_0000 | 32'(i)) : $urandom;
            i_ram_wen = 1; i_ram_wadr = AW'(i); i_ram_wdata = d;
            ram_m[i] = d;
            @(negedge clk);
        end
        i_ram_wen = 0;
        check_reset_state("reset");
        rst_n = 1;

        // 1: start at 0x10, stream A..D
        for (int i = 0; i < 6; i++) begin
            pc_start = tbl[i].start; start_adr = tbl[i].adr; id_ready = tbl[i].rdy;
            cyc();
            chk("tbl_valid", 32'(inst_valid_id), 32'(tbl[i].exp_v));
            chk("tbl_inst", inst_id, tbl[i].exp_inst);
            chk("tbl_pc_data", pc_data, tbl[i].exp_pcdata);
            if (tbl[i].exp_v) chk("tbl_pc_id", 32'(pc_id), 32'(tbl[i].exp_pc));
        end
        clear_in();

        // 2: back-pressure saturates the queue, then drains in order
        id_ready = 0; pc_start = 1; start_adr = 30'h20;
        cyc(); clear_in();
        repeat (10) cyc();
        chk("sat_level", 32'(fq_level), 32'd4);
        chk("sat_pc_data", pc_data, {30'h24, 2'b00});
        chk("sat_head", 32'(pc_id), 32'h20);
        id_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("drain_pc", 32'(pc_id), 32'h20 + 32'(i));
        end

        // 3: jump with 3 queued entries and a read in flight
        id_ready = 0; pc_start = 1; start_adr = 30'h30;
        cyc(); clear_in();
        repeat (4) cyc();
        chk("pre_jmp_level", 32'(fq_level), 32'd3);
        jmp_condition_ex = 1; jmp_adr_ex = 30'h40;
        cyc(); clear_in();
        chk("jmp_flush_level", 32'(fq_level), 32'd0);
        chk("jmp_post_jump", 32'(post_jump_cmd_cond), 32'd1);
        id_ready = 1;
        cyc();
        chk("jmp_post_jump_clr", 32'(post_jump_cmd_cond), 32'd0);
        chk("jmp_bubble", 32'(inst_valid_id), 32'd0);
        cyc();
        chk("jmp_first_pc", 32'(pc_id), 32'h40);

        // 4: jump right after a trap is suppressed
        trap_ex = 1; trap_vec_ex = 30'h80;
        cyc(); clear_in();
        jmp_condition_ex = 1; jmp_adr_ex = 30'h40;
        cyc(); clear_in();
        chk("trap_sup_pc_data", pc_data, {30'h81, 2'b00});
        cyc();
        chk("trap_first_pc", 32'(pc_id), 32'h80);

        // 5: priority trap > xret > jmp, pc_start over all
        trap_ex = 1; xret_ex = 1; jmp_condition_ex = 1;
        trap_vec_ex = 30'h88; xret_adr_ex = 30'h90; jmp_adr_ex = 30'hA0;
        cyc(); clear_in();
        chk("prio_trap", pc_data, {30'h88, 2'b00});
        cyc();
        pc_start = 1; start_adr = 30'hC0; trap_ex = 1; xret_ex = 1; jmp_condition_ex = 1;
        cyc(); clear_in();
        chk("prio_start", pc_data, {30'hC0, 2'b00});

        // 6: monitor reads stall fetch and never enter the queue
        repeat (3) cyc();
        saved_pc = m_fpc;
        i_read_sel = 1; i_ram_radr = 12'h5;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mon_ram5", i_ram_rdata, ram_m[5]);
            chk("mon_stall_pc", pc_data, {saved_pc, 2'b00});
        end
        clear_in();
        repeat (4) cyc();

        // PC wrap at the top of the 30-bit space
        pc_start = 1; start_adr = 30'h3FFF_FFFE;
        cyc(); clear_in();
        repeat (6) cyc();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pc_start         = ($urandom % 40) == 0;
            trap_ex          = ($urandom % 30) == 0;
            xret_ex          = ($urandom % 25) == 0;
            jmp_condition_ex = ($urandom % 12) == 0;
            start_adr   = (($urandom % 8) == 0) ? (30'h3FFF_FFFC | 30'($urandom % 4)) : 30'($urandom);
            trap_vec_ex = 30'($urandom);
            xret_adr_ex = 30'($urandom);
            jmp_adr_ex  = 30'($urandom);
            id_ready    = ($urandom % 10) < 7;
            i_read_sel  = ($urandom % 10) == 0;
            i_ram_radr  = AW'($urandom);
            i_ram_wen   = ($urandom % 10) == 0;
            i_ram_wadr  = (($urandom % 2) == 0) ? m_fpc[AW-1:0] : AW'($urandom);
            i_ram_wdata = $urandom;
            cyc();
        end
        clear_in();
        id_ready = 1;
        repeat (3) cyc();

        // Asynchronous reset mid-stream; RAM contents must survive
        #2 rst_n = 0;
        #1 check_reset_state("async_reset");
        m_reset();
        @(negedge clk);
        rst_n = 1;
        pc_start = 1; start_adr = 30'h10;
        cyc(); clear_in();
        repeat (20) cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
